// File: rtl/axi_defs_pkg.sv
// Shared AXI read-responder definitions: burst types, response codes,
// responder FSM states and the fixed beat size.
package axi_defs_pkg;

  localparam int unsigned BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    BURST
  } state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for an AXI burst.
//   cur_addr  : address of the beat just handshaken (8-byte aligned)
//   arlen     : burst length minus one
//   arburst   : FIXED / INCR / WRAP (reserved encoding behaves as INCR)
//   next_addr : address of the following beat
module axi_burst_addr_gen
  import axi_defs_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [7:0]        arlen,
  input  burst_e            arburst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  assign incr_addr = cur_addr + ADDR_W'(BEAT_BYTES);
  // Window is (arlen+1)*8 bytes; for power-of-two lengths its mask is arlen*8 + 7.
  assign wrap_mask = (ADDR_W'(arlen) << 3) | ADDR_W'(BEAT_BYTES - 1);
  assign wrap_ok   = (arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15);

  always_comb begin
    next_addr = incr_addr;
    case (arburst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP: begin
        // Illegal WRAP lengths fall through to INCR.
        if (wrap_ok) next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      end
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a 64-bit word memory with a preload port.
// Accepts one AR burst at a time, waits READ_LATENCY cycles, then streams beats on R.
// Optional feature macro: AXI_RESP_ERR_EN -- beats outside the memory window return
// SLVERR with zero data instead of aliasing.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   s_axi_ar*              : read address channel (arsize ignored, beats are 8 bytes)
//   s_axi_r*               : read data channel, all outputs registered
//   init_we/addr/data      : preload write into the backing memory, any state
module axi_read_responder
  import axi_defs_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 64,
  parameter int unsigned       DATA_W       = 64,
  parameter int unsigned       MEM_WORDS    = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);

  localparam int unsigned IdxW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned LatW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned LatInit = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(BEAT_BYTES - 1);

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = (addr - BASE_ADDR) >> 3;
    return IdxW'(word % ADDR_W'(MEM_WORDS));
  endfunction

`ifdef AXI_RESP_ERR_EN
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >= BASE_ADDR) &&
           ((addr - BASE_ADDR) < (ADDR_W'(MEM_WORDS) * ADDR_W'(BEAT_BYTES)));
  endfunction
`endif

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  state_e            state_q, state_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        len_q, len_d;
  burst_e            burst_q, burst_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] ar_addr_aligned;
  logic [DATA_W-1:0] beat_data;
  logic [1:0]        beat_resp;
  logic              load_beat;
  logic              ar_hs;
  logic              r_hs;
  logic              last_beat;
  logic              unused_arsize;

  assign unused_arsize   = ^s_axi_arsize;
  assign ar_addr_aligned = s_axi_araddr & AlignMask;
  assign ar_hs           = (state_q == IDLE) && arready_q && s_axi_arvalid;
  assign r_hs            = rvalid_q && s_axi_rready;
  assign last_beat       = (beat_cnt_q == len_q);

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .cur_addr (cur_addr_q),
    .arlen    (len_q),
    .arburst  (burst_q),
    .next_addr(next_addr)
  );

  // Memory read happens before any same-edge preload write lands, so a
  // colliding beat carries the old word.
  always_comb begin
    beat_data = mem_q[word_idx(fetch_addr)];
    beat_resp = RESP_OKAY;
`ifdef AXI_RESP_ERR_EN
    if (!in_range(fetch_addr)) begin
      beat_data = '0;
      beat_resp = RESP_SLVERR;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ar_hs) state_d = (READ_LATENCY == 0) ? BURST : LAT;
      LAT:     if (lat_cnt_q == '0) state_d = BURST;
      BURST:   if (r_hs && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    lat_cnt_d  = lat_cnt_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    burst_d    = burst_q;
    cur_addr_d = cur_addr_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    fetch_addr = cur_addr_q;
    load_beat  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          cur_addr_d = ar_addr_aligned;
          len_d      = s_axi_arlen;
          burst_d    = burst_e'(s_axi_arburst);
          beat_cnt_d = '0;
          lat_cnt_d  = LatW'(LatInit);
          if (READ_LATENCY == 0) begin
            fetch_addr = ar_addr_aligned;
            load_beat  = 1'b1;
          end
        end
      end
      LAT: begin
        if (lat_cnt_q == '0) load_beat = 1'b1;
        else lat_cnt_d = lat_cnt_q - LatW'(1);
      end
      BURST: begin
        if (r_hs) begin
          if (last_beat) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            cur_addr_d = next_addr;
            fetch_addr = next_addr;
            load_beat  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (load_beat) begin
      rvalid_d = 1'b1;
      rdata_d  = beat_data;
      rresp_d  = beat_resp;
      rlast_d  = (beat_cnt_d == len_d);
    end

    arready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      burst_q    <= BURST_FIXED;
      cur_addr_q <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      cur_addr_q <= cur_addr_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Backing store is not cleared by reset so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (init_we) mem_q[word_idx(init_addr)] <= init_data;
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_read_responder.sv
module tb_axi_read_responder;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MEM_WORDS = 8;
  localparam int unsigned LATENCY   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  int checks = 0;
  int errors = 0;

  axi_read_responder #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_WORDS   (MEM_WORDS),
    .BASE_ADDR   (64'h0),
    .READ_LATENCY(LATENCY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arlen  (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast),
    .init_we      (init_we),
    .init_addr    (init_addr),
    .init_data    (init_data)
  );

  always #5 clk = ~clk;

  // words: one hex nibble per beat, beat 0 in the top nibble; nibble n expects
  // 64'hA0+n with OKAY, nibble F expects zero data with SLVERR.
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [15:0] pat;
    logic [31:0] words;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [15:0] pat,
                              input logic [31:0] words);
    vec_t v;
    v.addr  = addr;
    v.len   = len;
    v.burst = burst;
    v.pat   = pat;
    v.words = words;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = addr;
    init_data = data;
    @(posedge clk);
    #1 init_we = 1'b0;
  endtask

  task automatic wait_arready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = s_axi_arready;
    end
    check("arready_wait", 64'(seen), 64'd1);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int   cyc, beat, first;
    bit   done;
    logic [3:0] nib;
    wait_arready();
    s_axi_araddr  = v.addr;
    s_axi_arlen   = v.len;
    s_axi_arburst = v.burst;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    cyc = 0; beat = 0; first = -1; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (s_axi_rvalid) begin
        if (first < 0) begin
          first = cyc;
          check($sformatf("v%0d first_rvalid_cycle", vi), 64'(cyc), 64'(1 + LATENCY));
        end
        nib = v.words[31 - 4*beat -: 4];
        check($sformatf("v%0d beat%0d rdata", vi, beat), s_axi_rdata,
              (nib == 4'hF) ? 64'h0 : 64'hA0 + 64'(nib));
        check($sformatf("v%0d beat%0d rresp", vi, beat), 64'(s_axi_rresp),
              (nib == 4'hF) ? 64'd2 : 64'd0);
        check($sformatf("v%0d beat%0d rlast", vi, beat), 64'(s_axi_rlast),
              64'(beat == int'(v.len)));
        s_axi_rready = (cyc - first < 16) ? v.pat[cyc - first] : 1'b1;
        if (s_axi_rready) begin
          beat++;
          if (beat == int'(v.len) + 1) done = 1'b1;
        end
      end else begin
        s_axi_rready = 1'b0;
      end
    end
    check($sformatf("v%0d completed", vi), 64'(done), 64'd1);
    @(negedge clk);
    s_axi_rready = 1'b0;
    check($sformatf("v%0d rvalid_after_last", vi), 64'(s_axi_rvalid), 64'd0);
    check($sformatf("v%0d arready_after_last", vi), 64'(s_axi_arready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = 3'b011; s_axi_arburst = 2'd1; s_axi_rready = 1'b0;
    init_we = 1'b0; init_addr = '0; init_data = '0;

    vecs[0] = mk(64'h20, 8'd3, 2'd1, 16'hFFFF, 32'h4567_0000);
    vecs[1] = mk(64'h30, 8'd3, 2'd2, 16'hFFFF, 32'h6745_0000);
    vecs[2] = mk(64'h20, 8'd3, 2'd1, 16'h9249, 32'h4567_0000);
    vecs[3] = mk(64'h18, 8'd2, 2'd0, 16'hFFFF, 32'h3330_0000);
    vecs[4] = mk(64'h3C, 8'd1, 2'd2, 16'hFFFF, 32'h7600_0000);
    vecs[5] = mk(64'h28, 8'd2, 2'd2, 16'hFFFF, 32'h5670_0000);
`ifdef AXI_RESP_ERR_EN
    vecs[6] = mk(64'h30, 8'd3, 2'd1, 16'hFFFF, 32'h67FF_0000);
`else
    vecs[6] = mk(64'h30, 8'd3, 2'd1, 16'hFFFF, 32'h6701_0000);
`endif
    vecs[7] = mk(64'h18, 8'd7, 2'd2, 16'hFFFF, 32'h3456_7012);
    vecs[8] = mk(64'h08, 8'd0, 2'd1, 16'hFFFF, 32'h1000_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset arready", 64'(s_axi_arready), 64'd0);
    check("reset rvalid", 64'(s_axi_rvalid), 64'd0);
    check("reset rlast", 64'(s_axi_rlast), 64'd0);
    check("reset rdata", s_axi_rdata, 64'd0);
    check("reset rresp", 64'(s_axi_rresp), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("arready after reset", 64'(s_axi_arready), 64'd1);

    for (int i = 0; i < 8; i++) preload(64'(i * 8), 64'hA0 + 64'(i));

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Preload collides with the load of the first beat of a FIXED burst.
    wait_arready();
    s_axi_araddr = 64'h10; s_axi_arlen = 8'd1; s_axi_arburst = 2'd0;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    init_we = 1'b1; init_addr = 64'h10; init_data = 64'hBB;
    @(negedge clk);
    init_we = 1'b0;
    check("collide beat0 rvalid", 64'(s_axi_rvalid), 64'd1);
    check("collide beat0 old data", s_axi_rdata, 64'hA2);
    @(negedge clk);
    check("collide beat1 new data", s_axi_rdata, 64'hBB);
    check("collide beat1 rlast", 64'(s_axi_rlast), 64'd1);
    @(negedge clk);
    s_axi_rready = 1'b0;
    check("collide done rvalid", 64'(s_axi_rvalid), 64'd0);
    preload(64'h10, 64'hA2);

    // Reset asserted while the second beat of an 8-beat burst is presented.
    wait_arready();
    s_axi_araddr = 64'h0; s_axi_arlen = 8'd7; s_axi_arburst = 2'd1;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst seq beat0", s_axi_rdata, 64'hA0);
    @(negedge clk);
    check("rst seq beat1", s_axi_rdata, 64'hA1);
    reset = 1'b1;
    @(negedge clk);
    check("rst seq rvalid dropped", 64'(s_axi_rvalid), 64'd0);
    check("rst seq arready in reset", 64'(s_axi_arready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst seq arready after release", 64'(s_axi_arready), 64'd1);
    check("rst seq no stray beat", 64'(s_axi_rvalid), 64'd0);
    s_axi_rready = 1'b0;
    run_vec(9, mk(64'h0, 8'd3, 2'd1, 16'hFFFF, 32'h0123_0000));

    // arvalid held high across an active burst.
    wait_arready();
    s_axi_araddr = 64'h0; s_axi_arlen = 8'd1; s_axi_arburst = 2'd1;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(posedge clk);
    #1 begin s_axi_araddr = 64'h38; s_axi_arlen = 8'd0; end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("hold arready c%0d", i), 64'(s_axi_arready), 64'd0);
      if (i == 3) check("hold first beat", s_axi_rdata, 64'hA0);
      if (i == 4) begin
        check("hold second beat", s_axi_rdata, 64'hA1);
        check("hold second rlast", 64'(s_axi_rlast), 64'd1);
      end
    end
    @(negedge clk);
    check("hold arready reopens", 64'(s_axi_arready), 64'd1);
    check("hold rvalid idle", 64'(s_axi_rvalid), 64'd0);
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("hold lat no rvalid", 64'(s_axi_rvalid), 64'd0);
    @(negedge clk);
    check("hold 2nd burst rvalid", 64'(s_axi_rvalid), 64'd1);
    check("hold 2nd burst rdata", s_axi_rdata, 64'hA7);
    check("hold 2nd burst rlast", 64'(s_axi_rlast), 64'd1);
    @(negedge clk);
    s_axi_rready = 1'b0;
    check("hold 2nd burst done", 64'(s_axi_rvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI4 read-channel responder (slave) backed by a 64-bit-wide word memory.
- It is the memory-side counterpart of the instruction-cache/fetch read path. It accepts AR requests, waits a configurable latency, then streams burst beats on R with RVALID/RREADY flow control.
- Serves as the simulation main-memory model for the fetch and data caches; a preload port fills it before the program runs.

Parameters:
- ADDR_W, 64, AR address width.
- DATA_W, 64, R data width; fixed 8-byte beats.
- MEM_WORDS, 4096, depth of the backing array in 64-bit words.
- BASE_ADDR, 64'h0, byte address mapped to word 0.
- READ_LATENCY, 2, idle cycles between AR handshake and first RVALID; 0 is legal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  ADDR_W  burst start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_arsize  in  3  beat size; only 3'b011 is meaningful
- s_axi_arburst  in  2  0=FIXED, 1=INCR, 2=WRAP
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  master ready for data
- s_axi_rdata  out  DATA_W  beat data
- s_axi_rresp  out  2  beat response
- s_axi_rlast  out  1  final beat of burst
- init_we  in  1  preload write enable
- init_addr  in  ADDR_W  preload byte address
- init_data  in  DATA_W  preload word

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: arready=0, rvalid=0, rlast=0, rdata=0, rresp=0. State is IDLE and counters are 0. Reset asserted mid-burst abandons the burst immediately, with no further beats.
- FSM IDLE -> LAT -> BURST -> IDLE.
  - IDLE: arready=1, starting the first cycle after reset deasserts.
  - On arvalid&&arready, capture araddr aligned down to 8 bytes, plus arlen and arburst; arready falls the next cycle.
  - If READ_LATENCY=0, go to BURST; otherwise go to LAT with the latency counter loaded.
- LAT: counter decrements each cycle; at 0, go to BURST.
  - First rvalid appears at cycle T+1+READ_LATENCY, where T is the AR handshake cycle.
- BURST:
  - rvalid=1; rdata = mem[idx(cur_addr)]; rlast=1 exactly when beat_cnt==arlen.
  - While rvalid&&!rready, rdata, rresp and rlast hold stable.
  - On handshake with a non-last beat: beat_cnt++, cur_addr advances, and the next beat is presented the following cycle. Back-to-back beats are allowed, one per cycle.
  - On handshake with the last beat: rvalid drops and the FSM returns to IDLE; arready=1 on the next cycle.
- Address advance:
  - FIXED: unchanged.
  - INCR: +8.
  - WRAP: +8 within a (arlen+1)*8-byte aligned window, wrapping to the window base. Legal only for arlen in {1,3,7,15}; any other arlen under WRAP is served as INCR.
- arsize other than 3 is served as 8-byte beats.
- Index: idx = ((addr - BASE_ADDR) >> 3) mod MEM_WORDS, so out-of-window addresses alias.
- One outstanding burst only; AR is never accepted outside IDLE.
- Preload: init_we writes mem[idx(init_addr)] at the clock edge, in any state.
  - A write in the same cycle that a beat of the same word is loaded: that beat carries the old value.
- rresp=2'b00 (OKAY) on every beat unless the optional feature below flags an error.

Optional Feature:
- Macro: AXI_RESP_ERR_EN.
- Defined: a beat whose address lies outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*8) returns rresp=2'b10 (SLVERR) and rdata=0. The burst still completes its full length; in-range beats of the same burst stay OKAY.
- Undefined: no range check; aliasing as above and rresp is always 2'b00.

Decomposition:
- Shared package axi_defs_pkg holds:
  - burst-type enum (BURST_FIXED=2'd0, BURST_INCR=2'd1, BURST_WRAP=2'd2);
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - responder state enum {IDLE, LAT, BURST};
  - BEAT_BYTES=8.
- One sub-module: axi_burst_addr_gen, purely combinational next-address logic computed from (cur_addr, arlen, arburst).

Test Plan:
- Preload words 0..7 with 64'hA0..A7; INCR burst araddr=0x20, arlen=3, rready=1, READ_LATENCY=2 -> first rvalid at T+3; rdata A4,A5,A6,A7 on consecutive cycles; rlast only on A7; arready high 1 cycle after.
- WRAP burst araddr=0x30, arlen=3 -> rdata A6,A7,A4,A5; rlast on A5.
- Same INCR burst with rready toggling 1,0,0,1,... -> each beat held stable while stalled; exactly 4 handshakes, none duplicated or dropped.
- Assert reset on the 2nd beat of an arlen=7 burst -> rvalid=0 the next cycle; arready=1 the cycle after reset releases; a new AR is served from its first beat.
- arvalid held high during an active burst -> arready stays 0; the second request is accepted only after the first burst's rlast handshake.
- With AXI_RESP_ERR_EN defined, MEM_WORDS=4: INCR burst araddr=0x10, arlen=3 -> rresp OKAY, OKAY, SLVERR, SLVERR; rdata 0 on the last two beats. Without the macro, the same stimulus gives all OKAY with aliased data A0,A1.
